// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared helpers for the N x N round-robin crossbar.
// Provides clog2, the derived select/count widths and the lane index helper.
package crossbar_pkg;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Width of a port index for n ports.
  function automatic int sel_w(input int n);
    return clog2(n);
  endfunction

  // Occupancy counter must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  // LSB of lane idx in a packed bus of w-bit lanes.
  function automatic int lane(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over N requests.
// Ports: req, ptr (first index searched), en -> grant, grant_idx, grant_valid.
module rr_arbiter
  import crossbar_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = sel_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [PW-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (en && !grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crossbar_nxn_rr.sv
// crossbar_nxn_rr: input-queued N x N crossbar, RR arbiter per output.
// Ports: clk, rst (sync, high); in_valid/in_ready/in_data/in_sel per input;
// out_valid/out_ready/out_data/out_src per output; fifo_count per input.
module crossbar_nxn_rr
  import crossbar_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 64,
  localparam int SEL_W  = sel_w(N_PORTS),
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_PORTS-1:0]       in_valid,
  output logic [N_PORTS-1:0]       in_ready,
  input  logic [N_PORTS*WIDTH-1:0] in_data,
  input  logic [N_PORTS*SEL_W-1:0] in_sel,
  output logic [N_PORTS-1:0]       out_valid,
  input  logic [N_PORTS-1:0]       out_ready,
  output logic [N_PORTS*WIDTH-1:0] out_data,
  output logic [N_PORTS*SEL_W-1:0] out_src,
  output logic [N_PORTS*CNT_W-1:0] fifo_count
);

  localparam int AW = clog2(DEPTH);
  localparam int NN = N_PORTS * N_PORTS;

  logic [N_PORTS-1:0] head_valid;
  logic [SEL_W-1:0]   head_sel  [N_PORTS];
  logic [WIDTH-1:0]   head_data [N_PORTS];
  logic [N_PORTS-1:0] req       [N_PORTS];
  logic [NN-1:0]      gnt_flat;
  logic [N_PORTS-1:0] pop;

  // req[o][i]: head of input i wants output o.
  always_comb begin
    for (int o = 0; o < N_PORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        req[o][i] = head_valid[i] &&
                    (head_sel[i] == SEL_W'(o));
      end
    end
  end

  // A head targets one output, so at most one grant per input.
  always_comb begin
    pop = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      pop = pop | gnt_flat[o*N_PORTS +: N_PORTS];
    end
  end

  for (genvar i = 0; i < N_PORTS; i++) begin : g_fifo
    logic [SEL_W+WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [SEL_W-1:0]       wsel;
    logic [WIDTH-1:0]       wdata;
    logic                   full;
    logic                   sel_ok;
    logic                   push;

    assign wsel  = in_sel[lane(i, SEL_W) +: SEL_W];
    assign wdata = in_data[lane(i, WIDTH) +: WIDTH];
    assign full  = (count == CNT_W'(DEPTH));

    // Unreachable destinations only exist for non-power-of-2 sizes.
    if (N_PORTS == (1 << SEL_W)) begin : g_pow2
      assign sel_ok = 1'b1;
    end else begin : g_npow2
      assign sel_ok = (wsel < SEL_W'(N_PORTS));
    end

    // Full blocks pushes even if a pop lands on the same edge.
    assign push = in_valid[i] && !full && sel_ok;

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop[i])
          rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop[i])
          count <= count + CNT_W'(1);
        else if (!push && pop[i])
          count <= count - CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push)
        mem[wr_ptr] <= {wsel, wdata};
    end

    assign head_valid[i] = (count != '0);
    assign {head_sel[i], head_data[i]} = mem[rd_ptr];
    assign in_ready[i] = !full;
    assign fifo_count[lane(i, CNT_W) +: CNT_W] = count;
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_out
    logic             load;
    logic             gv;
    logic [SEL_W-1:0] gi;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] src_q;

    assign load = !valid_q || out_ready[o];

    rr_arbiter #(
      .N (N_PORTS)
    ) u_arb (
      .req         (req[o]),
      .ptr         (ptr),
      .en          (load),
      .grant       (gnt_flat[o*N_PORTS +: N_PORTS]),
      .grant_idx   (gi),
      .grant_valid (gv)
    );

    assign ptr_nxt = (gi == SEL_W'(N_PORTS - 1)) ?
                     '0 : gi + SEL_W'(1);

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        src_q   <= '0;
        ptr     <= '0;
      end else if (gv) begin
        valid_q <= 1'b1;
        data_q  <= head_data[gi];
        src_q   <= gi;
        ptr     <= ptr_nxt;
      end else if (out_ready[o]) begin
        valid_q <= 1'b0;
      end
    end

    assign out_valid[o] = valid_q;
    assign out_data[lane(o, WIDTH) +: WIDTH] = data_q;
    assign out_src[lane(o, SEL_W) +: SEL_W]  = src_q;
  end

endmodule

// File: tb/tb_crossbar_nxn_rr.sv
// tb_crossbar_nxn_rr: vectors, directed corner cases and random traffic
// for crossbar_nxn_rr, checked against a queue-based reference model.
module tb_crossbar_nxn_rr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int D  = 64;
  localparam int SW = 2;
  localparam int CW = 7;

  logic            clk;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*W-1:0]  in_data;
  logic [N*SW-1:0] in_sel;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*W-1:0]  out_data;
  logic [N*SW-1:0] out_src;
  logic [N*CW-1:0] fifo_count;

  crossbar_nxn_rr #(
    .N_PORTS (N),
    .WIDTH   (W),
    .DEPTH   (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: queue of {sel,data} per input, register per output.
  logic [9:0] mq [N][$];
  logic [N-1:0] mv;
  logic [7:0] md [N];
  logic [1:0] ms [N];
  int mp [N];

  task automatic model_step();
    int sz [N];
    bit [N-1:0] pops;
    logic [9:0] h;
    pops = '0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mq[i].delete();
        md[i] = '0;
        ms[i] = '0;
        mp[i] = 0;
      end
      mv = '0;
      return;
    end
    for (int i = 0; i < N; i++) sz[i] = mq[i].size();
    for (int o = 0; o < N; o++) begin
      int g;
      g = -1;
      if (!mv[o] || out_ready[o]) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (mp[o] + k) % N;
          if (g < 0 && sz[i] > 0) begin
            h = mq[i][0];
            if (int'(h[9:8]) == o) g = i;
          end
        end
      end
      if (g >= 0) begin
        h = mq[g][0];
        md[o] = h[7:0];
        ms[o] = 2'(g);
        mv[o] = 1'b1;
        mp[o] = (g + 1) % N;
        pops[g] = 1'b1;
      end else if (out_ready[o] && mv[o]) begin
        mv[o] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (pops[i]) void'(mq[i].pop_front());
      if (in_valid[i] && sz[i] != D)
        mq[i].push_back({in_sel[i*SW +: SW], in_data[i*W +: W]});
    end
  endtask

  initial begin
    mv = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int o = 0; o < N; o++) begin
          chk($sformatf("m_valid%0d", o), 32'(out_valid[o]), 32'(mv[o]));
          if (mv[o]) begin
            chk($sformatf("m_data%0d", o), 32'(out_data[o*W +: W]), 32'(md[o]));
            chk($sformatf("m_src%0d", o), 32'(out_src[o*SW +: SW]), 32'(ms[o]));
          end
        end
        for (int i = 0; i < N; i++) begin
          chk($sformatf("m_ready%0d", i), 32'(in_ready[i]),
              32'(mq[i].size() != D));
          chk($sformatf("m_count%0d", i), 32'(fifo_count[i*CW +: CW]),
              32'(mq[i].size()));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0][7:0] d;
    logic [3:0][1:0] s;
    logic [3:0][7:0] ed;
    logic [3:0][1:0] es;
  } vec_t;

  vec_t tab [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int acc;

    tab[0] = '{d:  {8'hDD, 8'hCC, 8'hBB, 8'hAA},
               s:  {2'd3, 2'd2, 2'd1, 2'd0},
               ed: {8'hDD, 8'hCC, 8'hBB, 8'hAA},
               es: {2'd3, 2'd2, 2'd1, 2'd0}};
    tab[1] = '{d:  {8'h22, 8'h11, 8'hFF, 8'hEE},
               s:  {2'd0, 2'd3, 2'd2, 2'd1},
               ed: {8'h11, 8'hFF, 8'hEE, 8'h22},
               es: {2'd2, 2'd1, 2'd0, 2'd3}};
    tab[2] = '{d:  {8'h04, 8'h03, 8'h02, 8'h01},
               s:  {2'd2, 2'd3, 2'd0, 2'd1},
               ed: {8'h03, 8'h04, 8'h01, 8'h02},
               es: {2'd2, 2'd3, 2'd0, 2'd1}};

    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    in_sel = '0;
    out_ready = '1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_src", 32'(out_src), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ready", 32'(in_ready), 32'hF);

    // Single-cycle permutations.
    for (int v = 0; v < 3; v++) begin
      in_data = tab[v].d;
      in_sel = tab[v].s;
      in_valid = '1;
      tick();
      in_valid = '0;
      chk("tab_early", 32'(out_valid), 0);
      tick();
      chk($sformatf("tab%0d_valid", v), 32'(out_valid), 32'hF);
      for (int o = 0; o < N; o++) begin
        chk($sformatf("tab%0d_data%0d", v, o),
            32'(out_data[o*W +: W]), 32'(tab[v].ed[o]));
        chk($sformatf("tab%0d_src%0d", v, o),
            32'(out_src[o*SW +: SW]), 32'(tab[v].es[o]));
      end
      tick();
      chk($sformatf("tab%0d_drop", v), 32'(out_valid), 0);
    end

    // 4-way contention on output 3.
    do_reset();
    in_data = {8'hEE, 8'hDD, 8'hCC, 8'hBB};
    in_sel = {2'd3, 2'd3, 2'd3, 2'd3};
    in_valid = '1;
    tick();
    in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] e;
      e = 32'hEEDDCCBB;
      tick();
      chk("cont_valid", 32'(out_valid), 32'h8);
      chk("cont_data", 32'(out_data[31:24]), 32'(e[k*8 +: 8]));
      chk("cont_src", 32'(out_src[7:6]), k);
    end
    // Pointer back at 0: input 0 beats input 3.
    in_data = {8'h33, 8'h00, 8'h00, 8'h30};
    in_valid = 4'b1001;
    tick();
    in_valid = '0;
    tick();
    chk("cont_ptr_data", 32'(out_data[31:24]), 32'h30);
    chk("cont_ptr_src", 32'(out_src[7:6]), 0);
    tick();
    chk("cont_ptr_next", 32'(out_data[31:24]), 32'h33);
    repeat (3) tick();

    // Fairness between inputs 0 and 1 on output 0.
    in_sel = '0;
    for (int c = 0; c <= 10; c++) begin
      if (c < 5) begin
        in_data = {8'h00, 8'h00, 8'(8'h20 + c), 8'(8'h10 + c)};
        in_valid = 4'b0011;
      end else begin
        in_valid = '0;
      end
      tick();
      if (c >= 1) begin
        int k;
        k = c - 1;
        chk("fair_valid", 32'(out_valid[0]), 1);
        chk("fair_src", 32'(out_src[1:0]), k % 2);
        chk("fair_data", 32'(out_data[7:0]),
            ((k % 2) != 0 ? 32'h20 : 32'h10) + k / 2);
      end
    end
    tick();
    chk("fair_idle", 32'(out_valid), 0);

    // Backpressure: fill input 2 behind a stalled output 2.
    out_ready = 4'b1011;
    in_sel = {2'd0, 2'd2, 2'd0, 2'd0};
    acc = 0;
    for (int c = 0; c < 100 && in_ready[2]; c++) begin
      in_data = {8'h00, 8'(acc), 8'h00, 8'h00};
      in_valid = 4'b0100;
      tick();
      acc++;
    end
    chk("bp_accepted", acc, 65);
    chk("bp_ready", 32'(in_ready[2]), 0);
    chk("bp_count", 32'(fifo_count[20:14]), 64);
    chk("bp_out0", 32'(out_data[23:16]), 0);
    in_data = {8'h00, 8'hFF, 8'h00, 8'h00};
    tick();
    in_valid = '0;
    chk("bp_ignored", 32'(fifo_count[20:14]), 64);
    out_ready = '1;
    tick();
    chk("bp_reready", 32'(in_ready[2]), 1);
    chk("bp_first", 32'(out_data[23:16]), 1);
    for (int w = 2; w <= 64; w++) begin
      tick();
      chk("bp_valid", 32'(out_valid[2]), 1);
      chk("bp_order", 32'(out_data[23:16]), w);
    end
    tick();
    chk("bp_drain", 32'(out_valid), 0);

    // Reset mid-stream.
    out_ready = '0;
    for (int c = 0; c < 3; c++) begin
      in_data = $urandom;
      in_sel = 8'($urandom);
      in_valid = '1;
      tick();
    end
    in_valid = '0;
    chk("mid_busy", 32'(out_valid != 0), 1);
    do_reset();
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_data", out_data, 0);
    chk("mid_src", 32'(out_src), 0);
    chk("mid_count", 32'(fifo_count), 0);
    chk("mid_ready", 32'(in_ready), 32'hF);
    out_ready = '1;
    in_data = {8'h00, 8'h00, 8'h5A, 8'h00};
    in_sel = '0;
    in_valid = 4'b0010;
    tick();
    in_valid = '0;
    tick();
    chk("post_valid", 32'(out_valid), 1);
    chk("post_data", 32'(out_data[7:0]), 32'h5A);
    chk("post_src", 32'(out_src[1:0]), 1);

    // Random traffic: congested phase then mostly-flowing phase.
    for (int c = 0; c < 2000; c++) begin
      in_valid = 4'($urandom);
      in_data = $urandom;
      in_sel = 8'($urandom);
      for (int o = 0; o < N; o++) begin
        if (c < 800)
          out_ready[o] = ($urandom_range(0, 3) == 0);
        else
          out_ready[o] = ($urandom_range(0, 9) != 0);
      end
      if (c == 1500) rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    in_valid = '0;
    out_ready = '1;
    repeat (80) tick();
    chk("rand_drain", 32'(fifo_count), 0);

    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crossbar_nxn_rr.md
Name: crossbar_nxn_rr

Overview:
- Parametrised N x N input-queued crossbar. Successor to the fixed 4x4 crossbar.
- Each input port has its own FIFO holding {dest_sel, data}.
- Each output has a round-robin arbiter over the head-of-line requests and a registered output stage.
- Adds valid/ready backpressure on both sides, so no packet is silently dropped on contention.

Parameters:
- N_PORTS, 4, number of input ports and of output ports (>=2).
- WIDTH, 8, payload width in bits.
- DEPTH, 64, entries per input FIFO (power of 2, >=2).
- SEL_W, clog2(N_PORTS), destination select width (derived, not overridable).
- CNT_W, clog2(DEPTH)+1, FIFO occupancy counter width (derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  N_PORTS  per-input write strobe.
- in_ready  out  N_PORTS  per-input FIFO not full.
- in_data  in  N_PORTS*WIDTH  packed payloads; input i occupies [i*WIDTH +: WIDTH].
- in_sel  in  N_PORTS*SEL_W  packed destination output index per input.
- out_valid  out  N_PORTS  output register holds data.
- out_ready  in  N_PORTS  downstream accepts.
- out_data  out  N_PORTS*WIDTH  packed output payloads.
- out_src  out  N_PORTS*SEL_W  source input index of the current out_data.
- fifo_count  out  N_PORTS*CNT_W  per-input FIFO occupancy (debug/status).

Behaviour:
- Reset, synchronous, dominates everything:
  - all FIFOs empty, fifo_count=0, in_ready=all 1 in the cycle after reset.
  - out_valid=0, out_data=0, out_src=0.
  - all RR pointers=0, so input 0 has highest priority.
  - A reset mid-operation discards all queued and registered data.
- Push: at a rising edge with in_valid[i] && in_ready[i], {in_sel[i], in_data[i]} is written to FIFO i.
- in_ready[i] = (count_i != DEPTH), a function of registered count only.
  - No write-through when full, even if a pop happens in the same cycle.
  - in_valid while full is ignored, with no state change.
- Request: FIFO i non-empty asserts req[head_sel_i][i].
  - Each head targets exactly one output, so no input can be granted by two outputs.
- Load condition per output o: load_o = !out_valid[o] || out_ready[o].
- Arbitration per output o, combinational:
  - Search req[o] starting at ptr_o, wrapping N_PORTS-1 -> 0.
  - First hit is grant g, valid only if load_o.
- Transfer on a granted edge:
  - out_data[o] <= head_data_g, out_src[o] <= g, out_valid[o] <= 1.
  - FIFO g pops.
  - ptr_o <= (g+1) mod N_PORTS.
- No grant but out_ready[o] && out_valid[o]: out_valid[o] <= 0. ptr_o is unchanged when there is no grant.
- Pointer updates are independent per output.
- Simultaneous push and pop on the same FIFO: count unchanged, and both operations take effect.
- Latency and throughput:
  - Push at edge k into an empty FIFO; the head is visible after k.
  - Best-case grant at edge k+1; out_valid high after edge k+1, i.e. 2 cycles from in_valid to out_valid.
  - Full throughput is 1 word/cycle/output with out_ready held high.
- Ordering: per input, FIFO order is preserved. Head-of-line blocking is accepted by design: a blocked head stalls all later entries of that input.
- Pointer wrap-around: the counters use CNT_W bits and occupancy 0..DEPTH.
- Out-of-range in_sel can only occur when N_PORTS is not a power of 2. Such a value is dropped at push time: the entry is not written, but in_ready is still honoured.

Decomposition:
- crossbar_pkg holds the clog2 function, the SEL_W/CNT_W derivation, and the pack/unpack index macros or functions.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr, en; outputs grant one-hot, grant_idx, grant_valid. Instantiated N_PORTS times.
- The FIFO is inlined per input in a generate loop: memory, rd/wr pointers, count.

Test Plan:
- Identity map: N=4, data AA/BB/CC/DD, sel 0/1/2/3, out_ready=1.
  - Response: 2 cycles later out0..3 = AA/BB/CC/DD, out_src=0/1/2/3, all out_valid for 1 cycle.
- Rotation: EE/FF/11/22 with sel 1/2/3/0.
  - Response: out0=22 (src3), out1=EE, out2=FF, out3=11, same cycle.
- 4-way contention on output 3: BB/CC/DD/EE all sel 3, after reset.
  - Response: out3 delivers BB, CC, DD, EE on consecutive cycles.
  - Response: pointer ends at 0; other outputs stay invalid.
- Fairness: inputs 0 and 1 each stream 5 words to output 0.
  - Response: grants alternate 0,1,0,1,... with no starvation; all 10 words delivered in per-input order.
- Backpressure and full: out_ready[2]=0 while input 2 streams 65 words to output 2.
  - Response: 64+1 accepted (FIFO full plus the output register), then in_ready[2]=0 and fifo_count=64.
  - Release out_ready: all 65 words emerge in order, and in_ready reasserts one cycle after the first pop.
- Reset mid-stream: assert rst with FIFOs partially filled and out_valid high.
  - Response: next cycle all out_valid=0, counts=0, in_ready=1.
  - Response: after reset, a fresh push to input 1 sel 0 appears on out0 with src 1.
